// File: rtl/btn_event_ctrl.sv
// Button event sequencer: PRESS / HOLD / REPEAT / RELEASE from debounced levels, one shared timer.
// Optional macro BTN_EVT_REPEAT_EN enables auto-repeat; otherwise the FSM parks after HOLD until release.
module btn_event_ctrl #(
  parameter int N_BTN         = 4,
  parameter int IDX_W         = $clog2(N_BTN),
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [IDX_W-1:0] evt_btn,
  output logic             busy,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic [1:0]       dbg_state
);

  // Handshake: an event transfers on a rising clk edge where evt_valid && evt_ready; while
  // evt_valid is high and evt_ready is low, evt_code/evt_btn hold their value.

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HOLD_WAIT = 2'd1,
    S_REPEAT    = 2'd2
  } state_t;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_HOLD    = 2'd1;
  localparam logic [1:0] EVT_REPEAT  = 2'd2;
  localparam logic [1:0] EVT_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef BTN_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_CYCLES > 0);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] low_idx;
  logic             owner_pressed;
  logic             emit;
  logic [1:0]       emit_code;
  logic             load;

  always_comb begin
    low_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn_state[i]) low_idx = IDX_W'(i);
    end
  end

  assign owner_pressed = btn_state[owner_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    owner_d   = owner_q;
    emit      = 1'b0;
    emit_code = EVT_PRESS;
    case (state_q)
      S_IDLE: begin
        if (|btn_state) begin
          owner_d   = low_idx;
          timer_d   = '0;
          emit      = 1'b1;
          emit_code = EVT_PRESS;
          state_d   = S_HOLD_WAIT;
        end
      end
      S_HOLD_WAIT: begin
        // Release is checked first so it beats a same-cycle timer expiry.
        if (!owner_pressed) begin
          emit      = 1'b1;
          emit_code = EVT_RELEASE;
          state_d   = S_IDLE;
        end else if (timer_q == HOLD_LAST) begin
          emit      = 1'b1;
          emit_code = EVT_HOLD;
          timer_d   = '0;
          state_d   = S_REPEAT;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      S_REPEAT: begin
        if (!owner_pressed) begin
          emit      = 1'b1;
          emit_code = EVT_RELEASE;
          state_d   = S_IDLE;
`ifdef BTN_EVT_REPEAT_EN
        end else if (timer_q == REPEAT_LAST) begin
          emit      = 1'b1;
          emit_code = EVT_REPEAT;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
`else
        end else begin
          timer_d = '0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The FSM never waits for the consumer; an event that finds the buffer full is dropped.
  assign load = emit && (!evt_valid || evt_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid <= 1'b0;
      evt_code  <= 2'd0;
      evt_btn   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        evt_valid <= 1'b1;
        evt_code  <= emit_code;
        evt_btn   <= owner_d;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (emit && !load) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule
